// File: rtl/neokeon_pi2fun.sv
// Noekeon Pi2 step: fixed word rotations (right by 0/1/5/2) on a 128-bit state.
// Provides a combinational result for round chaining and a one-cycle registered copy.
module neokeon_pi2fun (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  input  logic [127:0] inDataState,
  output logic         outValid,
  output logic [127:0] outDataState,
  output logic [127:0] outDataStateComb
);

  logic [31:0] a0;
  logic [31:0] a1;
  logic [31:0] a2;
  logic [31:0] a3;
  logic [31:0] pi2A1;
  logic [31:0] pi2A2;
  logic [31:0] pi2A3;

  assign a0 = inDataState[127:96];
  assign a1 = inDataState[95:64];
  assign a2 = inDataState[63:32];
  assign a3 = inDataState[31:0];

  // Cyclic right rotations by 1, 5 and 2; these undo Pi1's left rotations.
  assign pi2A1 = {a1[0],   a1[31:1]};
  assign pi2A2 = {a2[4:0], a2[31:5]};
  assign pi2A3 = {a3[1:0], a3[31:2]};

  assign outDataStateComb = {a0, pi2A1, pi2A2, pi2A3};

  always_ff @(posedge inClk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (inRst) begin
      outValid     <= 1'b0;
      outDataState <= 128'h0;
    end else begin
      outValid <= inValid;
      if (inValid) begin
        outDataState <= outDataStateComb;
      end
    end
  end

endmodule

// File: tb/tb_neokeon_pi2fun.sv
// Directed self-checking bench for neokeon_pi2fun: reset, known vector, rotation
// boundaries, Pi1/Pi2 inverse stream, hold behaviour and reset priority.
module tb_neokeon_pi2fun;

  logic         inClk;
  logic         inRst;
  logic         inValid;
  logic [127:0] inDataState;
  logic         outValid;
  logic [127:0] outDataState;
  logic [127:0] outDataStateComb;

  int nCompared;
  int nMismatched;

  localparam logic [127:0] KnownIn  = 128'h7aa93d4ece14b678b3d291bb05537ff4;
  localparam logic [127:0] KnownOut = 128'h7aa93d4e670a5b3cdd9e948d0154dffd;
  localparam logic [127:0] BoundIn  = 128'h00000000_00000001_00000001_00000001;
  localparam logic [127:0] BoundOut = 128'h00000000_80000000_08000000_40000000;
  localparam logic [127:0] AllOnes  = {128{1'b1}};
  localparam logic [127:0] AllZeros = 128'h0;

  neokeon_pi2fun dut (
    .inClk           (inClk),
    .inRst           (inRst),
    .inValid         (inValid),
    .inDataState     (inDataState),
    .outValid        (outValid),
    .outDataState    (outDataState),
    .outDataStateComb(outDataStateComb)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] w, input int n);
    logic [63:0] d;
    d = {w, w} << n;
    return d[63:32];
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {s[127:96], rotl32(s[95:64], 1), rotl32(s[63:32], 5), rotl32(s[31:0], 2)};
  endfunction

  task automatic test_reset();
    inRst = 1'b1;
    inValid = 1'b1;
    inDataState = KnownIn;
    tick();
    tick();
    nCompared++;
    if (outValid !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_valid: got %b expected 0", outValid);
    end
    nCompared++;
    if (outDataState !== 128'h0) begin
      nMismatched++;
      $display("FAIL reset_data: got %h expected %h", outDataState, 128'h0);
    end
    inRst = 1'b0;
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_known_vector();
    inDataState = KnownIn;
    inValid = 1'b1;
    #1;
    nCompared++;
    if (outDataStateComb !== KnownOut) begin
      nMismatched++;
      $display("FAIL known_comb: got %h expected %h", outDataStateComb, KnownOut);
    end
    tick();
    inValid = 1'b0;
    nCompared++;
    if (outDataState !== KnownOut) begin
      nMismatched++;
      $display("FAIL known_reg: got %h expected %h", outDataState, KnownOut);
    end
    nCompared++;
    if (outValid !== 1'b1) begin
      nMismatched++;
      $display("FAIL known_valid: got %b expected 1", outValid);
    end
  endtask

  task automatic test_boundaries();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    vin[0] = BoundIn;  vexp[0] = BoundOut;
    vin[1] = AllOnes;  vexp[1] = AllOnes;
    vin[2] = AllZeros; vexp[2] = AllZeros;
    for (int i = 0; i < 3; i++) begin
      inDataState = vin[i];
      inValid = 1'b1;
      #1;
      nCompared++;
      if (outDataStateComb !== vexp[i]) begin
        nMismatched++;
        $display("FAIL boundary_comb[%0d]: got %h expected %h", i, outDataStateComb, vexp[i]);
      end
      tick();
      nCompared++;
      if (outDataState !== vexp[i] || outValid !== 1'b1) begin
        nMismatched++;
        $display("FAIL boundary_reg[%0d]: got %h/%b expected %h/1", i, outDataState, outValid, vexp[i]);
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_inverse();
    logic [127:0] orig;
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      inDataState = pi1(orig);
      inValid = 1'b1;
      #1;
      nCompared++;
      if (outDataStateComb !== orig) begin
        nMismatched++;
        $display("FAIL inverse_comb[%0d]: got %h expected %h", i, outDataStateComb, orig);
      end
      tick();
      nCompared++;
      if (outDataState !== orig || outValid !== 1'b1) begin
        nMismatched++;
        $display("FAIL inverse_reg[%0d]: got %h/%b expected %h/1", i, outDataState, outValid, orig);
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    inDataState = KnownIn;
    inValid = 1'b1;
    tick();
    nCompared++;
    if (outDataState !== KnownOut || outValid !== 1'b1) begin
      nMismatched++;
      $display("FAIL hold_load: got %h/%b expected %h/1", outDataState, outValid, KnownOut);
    end
    inValid = 1'b0;
    inDataState = AllOnes;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (outDataState !== KnownOut || outValid !== 1'b0) begin
        nMismatched++;
        $display("FAIL hold_cycle[%0d]: got %h/%b expected %h/0", i, outDataState, outValid, KnownOut);
      end
    end
  endtask

  task automatic test_reset_priority();
    inRst = 1'b1;
    inValid = 1'b1;
    inDataState = KnownIn;
    #1;
    nCompared++;
    if (outDataStateComb !== KnownOut) begin
      nMismatched++;
      $display("FAIL rstprio_comb: got %h expected %h", outDataStateComb, KnownOut);
    end
    tick();
    nCompared++;
    if (outDataState !== 128'h0 || outValid !== 1'b0) begin
      nMismatched++;
      $display("FAIL rstprio_clear: got %h/%b expected 0/0", outDataState, outValid);
    end
    inRst = 1'b0;
    inDataState = BoundIn;
    tick();
    inValid = 1'b0;
    nCompared++;
    if (outDataState !== BoundOut || outValid !== 1'b1) begin
      nMismatched++;
      $display("FAIL rstprio_release: got %h/%b expected %h/1", outDataState, outValid, BoundOut);
    end
    tick();
    nCompared++;
    if (outValid !== 1'b0) begin
      nMismatched++;
      $display("FAIL rstprio_pulse: got %b expected 0", outValid);
    end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    inRst = 1'b1;
    inValid = 1'b0;
    inDataState = '0;
    #1;
    test_reset();
    test_known_vector();
    test_boundaries();
    test_back_to_back_inverse();
    test_hold();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/neokeon_pi2fun.md
NEOKEON_PI2FUN -- requirements
Module: neokeon_pi2fun

Interface
Parameters: none; all widths are fixed.
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as in the codebase (inClk, inRst).
REQ-002 Port inClk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 Port inRst  input  1  synchronous active-high reset.
REQ-004 Port inValid  input  1  qualifies inDataState for one cycle.
REQ-005 Port inDataState  input  128  Noekeon state.
REQ-006 Port outValid  output  1  high for one cycle when outDataState holds a new result.
REQ-007 Port outDataState  output  128  Pi2-transformed state, registered.
REQ-008 Port outDataStateComb  output  128  combinational Pi2 of inDataState, for chaining inside a round datapath.

Function
REQ-009 State word mapping SHALL be fixed as follows:
- a0 = bits[127:96]
- a1 = bits[95:64]
- a2 = bits[63:32]
- a3 = bits[31:0]
REQ-010 Pi2 SHALL compute the output words as follows:
- out.a0 = a0
- out.a1 = a1 rotated right by 1
- out.a2 = a2 rotated right by 5
- out.a3 = a3 rotated right by 2
Rotations are 32-bit cyclic; no bits are lost.
REQ-011 outDataStateComb SHALL equal Pi2(inDataState) at all times, independent of inClk, inRst and inValid.
REQ-012 Data path latency SHALL be exactly 1 cycle:
- On a rising edge with inValid=1 and inRst=0: outDataState <= Pi2(inDataState), outValid <= 1.
REQ-013 On a rising edge with inValid=0 and inRst=0:
- outValid <= 0.
- outDataState SHALL hold its previous value.
REQ-014 There SHALL be no backpressure; a new input SHALL be accepted every cycle, supporting back-to-back throughput of 1 state/cycle.
REQ-015 Pi2 SHALL be the exact inverse of Pi1 (rotate-left by 1, 5, 2 on a1, a2, a3), so Pi2(Pi1(x)) = x for all x.

Reset
REQ-016 On a rising edge with inRst=1:
- outValid <= 0.
- outDataState <= 128'h0.
- inRst SHALL override inValid.
REQ-017 Reset asserted mid-stream SHALL discard the sample presented in that cycle; the first valid sample after reset release SHALL appear one cycle after its capture.
REQ-018 outDataStateComb SHALL be unaffected by reset.

Verification
REQ-019 Reset: hold inRst=1 for 2 cycles -> outValid=0, outDataState=128'h0.
REQ-020 Known vector: inDataState=128'h7aa93d4ece14b678b3d291bb05537ff4 with inValid=1 -> outDataStateComb=128'h7aa93d4e670a5b3cdd9e948d0154dffd immediately; one edge later outDataState carries the same value and outValid=1.
REQ-021 Rotation boundaries: inDataState=128'h00000000_00000001_00000001_00000001 -> 128'h00000000_80000000_08000000_40000000; all-ones input -> all-ones output; all-zeros input -> all-zeros output.
REQ-022 Inverse check: apply Pi1 in the bench to 1000 random states, feed the results back-to-back with inValid=1 -> each output equals the original state, with outValid high on every cycle.
REQ-023 Hold and reset priority: the known vector with inValid=1 followed by 3 cycles with inValid=0 -> outDataState holds the result and outValid=0 after the first cycle; inRst=1 together with inValid=1 -> outputs cleared, no outValid pulse.
